// File: rtl/panel_input_conditioner.sv
// Front-panel conditioning: 2-flop synchronisers, per-button debounce, blanked and
// arbitrated one-cycle command pulses, and a stability-filtered, lockable mode selector.

module panel_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  logic             sync1, sync2, deb, deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // this edge is the DEBOUNCE_CYCLES-th consecutive mismatch
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = deb & ~deb_d;
endmodule

module panel_input_conditioner #(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int KNOB_STABLE_CYCLES = 8,
  parameter int BLANK_CYCLES       = 16,
  parameter int CNT_W              = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_pause_raw,
  input  logic       btn_continue_raw,
  input  logic       btn_confirm_raw,
  input  logic       btn_temp_raw,
  input  logic       btn_spin_raw,
  input  logic [2:0] mode_knob_raw,
  input  logic       cycle_complete,
  output logic       start,
  output logic       stop,
  output logic       pause,
  output logic       continue_signal,
  output logic       confirm_wash_mode,
  output logic       change_temperature,
  output logic       change_spin_speed,
  output logic [2:0] wash_mode,
  output logic       mode_locked
);
  localparam int NUM_LANES = 7;
  localparam int L_START = 0, L_STOP = 1, L_PAUSE = 2, L_CONT = 3;
  localparam int L_CONFIRM = 4, L_TEMP = 5, L_SPIN = 6;
  localparam logic [CNT_W-1:0] KNOB_TGT = CNT_W'(KNOB_STABLE_CYCLES);

  typedef struct packed {
    logic spin;
    logic temp;
    logic confirm;
    logic cont;
    logic pause;
    logic stop;
    logic start;
  } cmd_t;

  logic [NUM_LANES-1:0] btn_raw, rise, qual;
  logic [2:0]           knob_s1, knob_s2, knob_prev;
  logic [CNT_W-1:0]     knob_cnt, knob_cnt_nxt, blank_cnt;
  logic                 knob_same, blank_on, cc_d, cc_rise, lock_clr;
  cmd_t                 cmd_d, cmd_q;

  assign btn_raw = {btn_spin_raw, btn_temp_raw, btn_confirm_raw, btn_continue_raw,
                    btn_pause_raw, btn_stop_raw, btn_start_raw};

  panel_input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_raw),
    .rise (rise)
  );

  // edges seen while blanking are dropped outright, never deferred
  assign blank_on = (blank_cnt != '0);
  assign qual     = blank_on ? '0 : rise;

  always_comb begin
    cmd_d = '0;
    if (qual[L_STOP])       cmd_d.stop  = 1'b1;
    else if (qual[L_PAUSE]) cmd_d.pause = 1'b1;
    else if (qual[L_CONT])  cmd_d.cont  = 1'b1;
    else if (qual[L_START]) cmd_d.start = 1'b1;
    cmd_d.confirm = qual[L_CONFIRM] & ~mode_locked;
    cmd_d.temp    = qual[L_TEMP]    & ~mode_locked;
    cmd_d.spin    = qual[L_SPIN]    & ~mode_locked;
  end

  assign cc_rise   = cycle_complete & ~cc_d;
  assign lock_clr  = cmd_q.stop | cc_rise;
  assign knob_same = (knob_s2 == knob_prev);

  // saturating run length of unchanged selector samples
  always_comb begin
    knob_cnt_nxt = '0;
    if (knob_same) knob_cnt_nxt = (knob_cnt == KNOB_TGT) ? knob_cnt : knob_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      knob_s1     <= '0;
      knob_s2     <= '0;
      knob_prev   <= '0;
      knob_cnt    <= '0;
      wash_mode   <= '0;
      mode_locked <= 1'b0;
      blank_cnt   <= CNT_W'(BLANK_CYCLES);
      cc_d        <= 1'b0;
      cmd_q       <= '0;
    end else begin
      knob_s1   <= mode_knob_raw;
      knob_s2   <= knob_s1;
      knob_prev <= knob_s2;
      knob_cnt  <= knob_cnt_nxt;
      if (knob_cnt_nxt == KNOB_TGT && !mode_locked) wash_mode <= knob_s2;
      if (blank_on) blank_cnt <= blank_cnt - CNT_W'(1);
      cc_d  <= cycle_complete;
      cmd_q <= cmd_d;
      if (lock_clr)           mode_locked <= 1'b0;
      else if (cmd_q.confirm) mode_locked <= 1'b1;
    end
  end

  assign start              = cmd_q.start;
  assign stop               = cmd_q.stop;
  assign pause              = cmd_q.pause;
  assign continue_signal    = cmd_q.cont;
  assign confirm_wash_mode  = cmd_q.confirm;
  assign change_temperature = cmd_q.temp;
  assign change_spin_speed  = cmd_q.spin;
endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts pulses and mode state per
// edge; a negedge monitor pops and compares against the DUT.

module tb_panel_input_conditioner;
  localparam int D  = 4;
  localparam int K  = 8;
  localparam int B  = 16;
  localparam int HN = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] btn = '0;
  logic [2:0] mode_in = '0;
  logic       cc = 1'b0;
  logic       start, stop, pause, continue_signal, confirm_wash_mode;
  logic       change_temperature, change_spin_speed, mode_locked;
  logic [2:0] wash_mode;
  logic [6:0] dut_cmd;

  always #5 clk = ~clk;

  panel_input_conditioner dut (
    .clk               (clk),
    .reset             (reset),
    .btn_start_raw     (btn[0]),
    .btn_stop_raw      (btn[1]),
    .btn_pause_raw     (btn[2]),
    .btn_continue_raw  (btn[3]),
    .btn_confirm_raw   (btn[4]),
    .btn_temp_raw      (btn[5]),
    .btn_spin_raw      (btn[6]),
    .mode_knob_raw     (mode_in),
    .cycle_complete    (cc),
    .start             (start),
    .stop              (stop),
    .pause             (pause),
    .continue_signal   (continue_signal),
    .confirm_wash_mode (confirm_wash_mode),
    .change_temperature(change_temperature),
    .change_spin_speed (change_spin_speed),
    .wash_mode         (wash_mode),
    .mode_locked       (mode_locked)
  );

  assign dut_cmd = {change_spin_speed, change_temperature, confirm_wash_mode,
                    continue_signal, pause, stop, start};

  int tests = 0;
  int fails = 0;
  int n = -1;

  // reference model state
  logic [6:0] hb [HN];
  logic [2:0] hk [HN];
  int         last_r = 0;
  logic [6:0] m_deb = '0, m_pend = '0, m_out = '0;
  logic       m_locked = 1'b0, m_cc_prev = 1'b0;
  logic [2:0] m_wash = '0;

  typedef struct { int cyc; logic [6:0] cmd; } pev_t;
  typedef struct { int cyc; logic [2:0] wash; logic lck; } sev_t;
  pev_t pq[$];
  sev_t sq[$];

  // synchronised view at edge m: raw from two edges earlier, zero right after reset
  function automatic logic sb(int m, int i);
    return (m - 2 > last_r) ? hb[m-2][i] : 1'b0;
  endfunction
  function automatic logic [2:0] ks(int m);
    return (m - 2 > last_r) ? hk[m-2] : 3'd0;
  endfunction

  task automatic model_step();
    logic [6:0] qual, nout;
    logic       blank_ok, ccr, win;
    logic [2:0] k0;
    hb[n] = btn;
    hk[n] = mode_in;
    if (!reset) begin
      last_r = n; m_deb = '0; m_pend = '0; m_out = '0;
      m_locked = 1'b0; m_wash = '0; m_cc_prev = 1'b0;
    end else begin
      blank_ok = (n - 1 - last_r) >= B;
      qual = blank_ok ? m_pend : 7'd0;
      if (m_locked) qual[6:4] = 3'b000;
      nout = '0;
      nout[6:4] = qual[6:4];
      if (qual[1])      nout[1] = 1'b1;
      else if (qual[2]) nout[2] = 1'b1;
      else if (qual[3]) nout[3] = 1'b1;
      else if (qual[0]) nout[0] = 1'b1;
      ccr = cc && !m_cc_prev;
      m_cc_prev = cc;
      if (!m_locked && (n - last_r) >= K) begin
        k0 = ks(n);
        win = 1'b1;
        for (int m = n - K; m < n; m++) if (ks(m) != k0) win = 1'b0;
        if (win) m_wash = k0;
      end
      if (m_out[1] || ccr) m_locked = 1'b0;
      else if (m_out[4])   m_locked = 1'b1;
      m_pend = '0;
      for (int i = 0; i < 7; i++) begin
        if (n - D + 1 > last_r) begin
          win = 1'b1;
          for (int m = n - D + 1; m <= n; m++) if (sb(m, i) == m_deb[i]) win = 1'b0;
          if (win) begin
            m_deb[i]  = ~m_deb[i];
            m_pend[i] = m_deb[i];
          end
        end
      end
      m_out = nout;
    end
    sq.push_back('{n, m_wash, m_locked});
    if (m_out != 7'd0) pq.push_back('{n, m_out});
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    model_step();
    #1;
  endtask

  task automatic hold(input int c);
    repeat (c) tick();
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (n >= 0) begin
        while (sq.size() > 0 && sq[0].cyc <= n) begin
          tests++;
          if (sq[0].cyc != n || wash_mode !== sq[0].wash || mode_locked !== sq[0].lck) begin
            fails++;
            $display("FAIL state cyc=%0d wash got=%0d exp=%0d locked got=%b exp=%b",
                     n, wash_mode, sq[0].wash, mode_locked, sq[0].lck);
          end
          void'(sq.pop_front());
        end
        while (pq.size() > 0 && pq[0].cyc < n) begin
          tests++; fails++;
          $display("FAIL missed_pulse cyc=%0d got=none exp=%b", pq[0].cyc, pq[0].cmd);
          void'(pq.pop_front());
        end
        if (dut_cmd != 7'd0) begin
          tests++;
          if (pq.size() > 0 && pq[0].cyc == n) begin
            if (dut_cmd !== pq[0].cmd) begin
              fails++;
              $display("FAIL pulse cyc=%0d got=%b exp=%b", n, dut_cmd, pq[0].cmd);
            end
            void'(pq.pop_front());
          end else begin
            fails++;
            $display("FAIL extra_pulse cyc=%0d got=%b exp=0000000", n, dut_cmd);
          end
        end else if (pq.size() > 0 && pq[0].cyc == n) begin
          tests++; fails++;
          $display("FAIL missed_pulse cyc=%0d got=0000000 exp=%b", n, pq[0].cmd);
          void'(pq.pop_front());
        end
      end
    end
  end

  initial begin
    int p;
    bit seen;
    hold(2);
    reset = 1'b1;
    hold(18);
    // start held from edge 20: pulse expected right after edge 20+2+D
    btn[0] = 1'b1;
    p = n + 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (start === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || n != p + 2 + D) begin
      fails++;
      $display("FAIL start_latency got_edge=%0d seen=%0d exp_edge=%0d", n, seen, p + 2 + D);
    end
    hold(6); btn[0] = 1'b0; hold(12); btn[0] = 1'b1; hold(10); btn[0] = 1'b0; hold(12);
    // stop glitch 3 cycles, then 4 stable cycles
    btn[1] = 1'b1; hold(3); btn[1] = 1'b0; hold(12);
    btn[1] = 1'b1; hold(4); btn[1] = 1'b0; hold(12);
    // pause held through reset, then re-pressed after blanking
    btn[2] = 1'b1; hold(2); reset = 1'b0; hold(2); reset = 1'b1; hold(20);
    btn[2] = 1'b0; hold(12); btn[2] = 1'b1; hold(8); btn[2] = 1'b0; hold(12);
    // coincident stop and start
    btn[1] = 1'b1; btn[0] = 1'b1; hold(8); btn = '0; hold(12);
    // mode selector bounce, confirm lock, selector moved and temp pressed while locked
    mode_in = 3'd5; hold(4); mode_in = 3'd3; hold(1); mode_in = 3'd5; hold(20);
    btn[4] = 1'b1; hold(8); btn[4] = 1'b0; hold(12);
    mode_in = 3'd2; hold(20);
    btn[5] = 1'b1; hold(8); btn[5] = 1'b0; hold(12);
    // cycle_complete releases the lock
    cc = 1'b1; hold(1); cc = 1'b0; hold(20);
    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 7; i++) if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 15) == 0) mode_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) cc = ~cc;
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1; btn = '0; cc = 1'b0;
    hold(20);
    @(negedge clk);
    #1;
    while (pq.size() > 0) begin
      tests++; fails++;
      $display("FAIL missed_pulse cyc=%0d got=none exp=%b", pq[0].cyc, pq[0].cmd);
      void'(pq.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
